// File: rtl/prbs_pkg.sv
// Shared types and constants for the 8-bit PRBS checker (x^8+x^4+x^3+x^2+1).
package prbs_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Taps 7,3,2,1 of the history register feed the next bit.
    localparam logic [7:0] TAP_MASK = 8'b1000_1110;
    localparam int         SEQ_LEN  = 255;

    function automatic logic prbs_next(input logic [7:0] hist);
        return ^(hist & TAP_MASK);
    endfunction

endpackage

// File: rtl/prbs_predictor_8.sv
// History register and tap XOR; loads either the received bit or its own prediction.
module prbs_predictor_8
    import prbs_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       shift,
    input  logic       use_pred,
    input  logic       bit_in,
    output logic       pred,
    output logic [7:0] hist
);

    assign pred = prbs_next(hist);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= 8'h00;
        end else if (shift) begin
            hist <= {hist[6:0], use_pred ? pred : bit_in};
        end
    end

endmodule

// File: rtl/prbs_checker_8.sv
// Self-synchronising PRBS-8 checker: searches, verifies, then counts bit errors while locked.
module prbs_checker_8
    import prbs_pkg::*;
#(
    parameter int LOCK_COUNT = 16,
    parameter int LOSS_COUNT = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             bit_in,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [7:0]       data_out
);

    localparam int             RUN_W    = $clog2(SEQ_LEN + 1);
    localparam logic [RUN_W-1:0] LOCK_LIM = RUN_W'(LOCK_COUNT);
    localparam logic [RUN_W-1:0] LOSS_LIM = RUN_W'(LOSS_COUNT);

    state_t           state, state_nx;
    logic [3:0]       fill, fill_nx;
    logic [RUN_W-1:0] run, run_nx, run_inc;
    logic [7:0]       hist, shifted;
    logic             pred, mismatch, err_hit;

    // Once locked the predictor free-runs, so a channel error is never fed back into hist.
    prbs_predictor_8 u_pred (
        .clk      (clk),
        .rst      (rst),
        .shift    (en),
        .use_pred (state == LOCKED),
        .bit_in   (bit_in),
        .pred     (pred),
        .hist     (hist)
    );

    assign mismatch = en & (bit_in != pred);
    assign err_hit  = mismatch & (state == LOCKED);
    assign shifted  = {hist[6:0], bit_in};
    assign run_inc  = run + RUN_W'(1);
    assign data_out = hist;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
        state_nx = state;
        fill_nx  = fill;
        run_nx   = run;
        if (en) begin
            case (state)
                SEARCH: begin
                    if (fill == 4'd7) begin
                        fill_nx = 4'd0;
                        if (shifted != 8'h00) begin
                            state_nx = VERIFY;
                            run_nx   = '0;
                        end
                    end else begin
                        fill_nx = fill + 4'd1;
                    end
                end
                VERIFY: begin
                    if (mismatch) begin
                        state_nx = SEARCH;
                        fill_nx  = 4'd0;
                    end else if (run_inc == LOCK_LIM) begin
                        state_nx = LOCKED;
                        run_nx   = '0;
                    end else begin
                        run_nx = run_inc;
                    end
                end
                LOCKED: begin
                    if (!mismatch) begin
                        run_nx = '0;
                    end else if (run_inc == LOSS_LIM) begin
                        state_nx = SEARCH;
                        fill_nx  = 4'd0;
                        run_nx   = '0;
                    end else begin
                        run_nx = run_inc;
                    end
                end
                default: state_nx = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SEARCH;
            fill      <= 4'd0;
            run       <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nx;
            fill      <= fill_nx;
            run       <= run_nx;
            locked    <= (state_nx == LOCKED);
            err_pulse <= err_hit;
            // Clear wins over a simultaneous error; the count saturates at all-ones.
            if (clr_cnt) begin
                err_count <= '0;
            end else if (err_hit && (err_count != '1)) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_prbs_checker_8.sv
// Randomised bench for prbs_checker_8 against a sequence-level reference model.
module tb_prbs_checker_8;
    import prbs_pkg::*;

    localparam int LOCK_N   = 16;
    localparam int LOSS_N   = 8;
    localparam int M_SEARCH = 0;
    localparam int M_VERIFY = 1;
    localparam int M_LOCKED = 2;

    logic        clk = 1'b0;
    logic        rst, en, bit_in, clr_cnt;
    logic        locked, err_pulse, locked4, err_pulse4;
    logic [15:0] err_count;
    logic [3:0]  err_count4;
    logic [7:0]  data_out, data_out4;

    always #5 clk = ~clk;

    prbs_checker_8 #(.LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .bit_in(bit_in), .clr_cnt(clr_cnt),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .data_out(data_out)
    );

    prbs_checker_8 #(.LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .bit_in(bit_in), .clr_cnt(clr_cnt),
        .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4), .data_out(data_out4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the received/predicted sequence is kept as a queue of its last 8 bits.
    int         m_mode, m_fill, m_run;
    bit         seq[$];
    bit         exp_locked, exp_pulse;
    int         exp_cnt16, exp_cnt4;
    logic [7:0] gen;

    function automatic bit gen_bit();
        gen = {gen[6:0], gen[7] ^ gen[3] ^ gen[2] ^ gen[1]};
        return gen[0];
    endfunction

    function automatic logic [7:0] exp_hist();
        logic [7:0] h;
        for (int i = 0; i < 8; i++) h[7-i] = seq[i];
        return h;
    endfunction

    task automatic model_reset();
        m_mode = M_SEARCH; m_fill = 0; m_run = 0;
        seq.delete();
        repeat (8) seq.push_back(1'b0);
        exp_locked = 0; exp_pulse = 0; exp_cnt16 = 0; exp_cnt4 = 0;
    endtask

    task automatic model_step(input bit e, input bit b, input bit c);
        bit p, hit;
        p   = seq[0] ^ seq[4] ^ seq[5] ^ seq[6];
        hit = 0;
        if (e) begin
            seq.push_back((m_mode == M_LOCKED) ? p : b);
            seq.delete(0);
            if (m_mode == M_SEARCH) begin
                m_fill++;
                if (m_fill == 8) begin
                    m_fill = 0;
                    if (exp_hist() != 8'h00) begin m_mode = M_VERIFY; m_run = 0; end
                end
            end else if (m_mode == M_VERIFY) begin
                if (b != p) begin
                    m_mode = M_SEARCH; m_fill = 0;
                end else begin
                    m_run++;
                    if (m_run == LOCK_N) begin m_mode = M_LOCKED; m_run = 0; end
                end
            end else begin
                if (b != p) begin
                    hit = 1;
                    m_run++;
                    if (m_run == LOSS_N) begin m_mode = M_SEARCH; m_fill = 0; m_run = 0; end
                end else begin
                    m_run = 0;
                end
            end
        end
        exp_pulse = hit;
        if (c) begin
            exp_cnt16 = 0; exp_cnt4 = 0;
        end else if (hit) begin
            if (exp_cnt16 < 65535) exp_cnt16++;
            if (exp_cnt4 < 15) exp_cnt4++;
        end
        exp_locked = (m_mode == M_LOCKED);
    endtask

    task automatic drive(input bit e, input bit b, input bit c);
        @(negedge clk);
        en = e; bit_in = b; clr_cnt = c;
        model_step(e, b, c);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; bit_in = 1'b0; clr_cnt = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; bit_in = 1'b0; clr_cnt = 1'b0;
        #3;
        n_cmp++;
        if ({locked, err_pulse, err_count, data_out, locked4, err_count4} !== 30'd0) begin
            n_bad++;
            $display("FAIL reset_state: got locked=%b pulse=%b cnt=%h hist=%h cnt4=%h want all zero",
                     locked, err_pulse, err_count, data_out, err_count4);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_clean_lock();
        apply_reset();
        gen = 8'h01;
        for (int i = 1; i <= 1024; i++) begin
            drive(1'b1, gen_bit(), 1'b0);
            n_cmp++;
            if ({locked, err_pulse, err_count, data_out} !== {exp_locked, exp_pulse, 16'(exp_cnt16), exp_hist()}) begin
                n_bad++;
                $display("FAIL clean_lock bit %0d: got %b/%b/%h/%h want %b/%b/%h/%h", i,
                         locked, err_pulse, err_count, data_out, exp_locked, exp_pulse, 16'(exp_cnt16), exp_hist());
            end
            if (i == 23 || i == 24 || i == 1024) begin
                n_cmp++;
                if (locked !== (i >= 24) || err_count !== 16'd0 || err_pulse !== 1'b0) begin
                    n_bad++;
                    $display("FAIL clean_lock_time bit %0d: got locked=%b cnt=%0d want locked=%b cnt=0",
                             i, locked, err_count, (i >= 24));
                end
            end
        end
    endtask

    task automatic test_single_error();
        int pulses = 0;
        for (int i = 0; i < 41; i++) begin
            drive(1'b1, (i == 20) ? !gen_bit() : gen_bit(), 1'b0);
            if (err_pulse === 1'b1) pulses++;
            n_cmp++;
            if ({locked, err_pulse, err_count} !== {1'b1, (i == 20), 16'(exp_cnt16)} || exp_cnt16 != int'(i >= 20)) begin
                n_bad++;
                $display("FAIL single_error step %0d: got locked=%b pulse=%b cnt=%0d want 1/%b/%0d",
                         i, locked, err_pulse, err_count, (i == 20), int'(i >= 20));
            end
        end
        n_cmp++;
        if (pulses != 1 || err_count !== 16'd1) begin
            n_bad++;
            $display("FAIL single_error_total: got pulses=%0d cnt=%0d want 1/1", pulses, err_count);
        end
    endtask

    task automatic test_loss_of_lock();
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, !gen_bit(), 1'b0);
            n_cmp++;
            if ({locked, err_pulse, err_count} !== {(k < 8), 1'b1, 16'(1 + k)}) begin
                n_bad++;
                $display("FAIL loss_error %0d: got locked=%b pulse=%b cnt=%0d want %b/1/%0d",
                         k, locked, err_pulse, err_count, (k < 8), 1 + k);
            end
        end
        for (int i = 1; i <= 24; i++) begin
            drive(1'b1, gen_bit(), 1'b0);
            n_cmp++;
            if ({locked, err_pulse, err_count, data_out} !== {(i == 24), 1'b0, 16'd9, exp_hist()} || exp_locked != (i == 24)) begin
                n_bad++;
                $display("FAIL relock bit %0d: got locked=%b pulse=%b cnt=%0d hist=%h want %b/0/9/%h",
                         i, locked, err_pulse, err_count, data_out, (i == 24), exp_hist());
            end
        end
    endtask

    task automatic test_invalid_stream();
        apply_reset();
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (locked !== 1'b0 || dut.state !== SEARCH || data_out !== 8'h00 || exp_locked) begin
                n_bad++;
                $display("FAIL invalid_stream bit %0d: got locked=%b state=%0d hist=%h want 0/SEARCH/00",
                         i, locked, dut.state, data_out);
            end
        end
        gen = 8'(($urandom_range(1, 255)));
        for (int i = 0; i < 60; i++) begin
            drive(1'b1, gen_bit(), 1'b0);
            n_cmp++;
            if ({locked, err_pulse, data_out} !== {exp_locked, exp_pulse, exp_hist()} || (i == 59 && !exp_locked)) begin
                n_bad++;
                $display("FAIL invalid_recover bit %0d: got %b/%b/%h want %b/%b/%h", i,
                         locked, err_pulse, data_out, exp_locked, exp_pulse, exp_hist());
            end
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        gen = 8'h01;
        for (int i = 0; i < 24 + 200; i++) begin
            drive(1'b1, (i >= 24 && (i % 10) == 9) ? !gen_bit() : gen_bit(), 1'b0);
            n_cmp++;
            if ({locked4, err_pulse4, err_count4, err_count} !== {exp_locked, exp_pulse, 4'(exp_cnt4), 16'(exp_cnt16)}) begin
                n_bad++;
                $display("FAIL saturation step %0d: got %b/%b/%0d/%0d want %b/%b/%0d/%0d", i,
                         locked4, err_pulse4, err_count4, err_count, exp_locked, exp_pulse, exp_cnt4, exp_cnt16);
            end
        end
        n_cmp++;
        if (err_count4 !== 4'd15 || err_count !== 16'd20 || locked !== 1'b1) begin
            n_bad++;
            $display("FAIL saturation_final: got cnt4=%0d cnt16=%0d locked=%b want 15/20/1",
                     err_count4, err_count, locked);
        end
        drive(1'b1, !gen_bit(), 1'b1);
        n_cmp++;
        if ({err_count4, err_count, err_pulse, err_pulse4, locked} !== {4'd0, 16'd0, 3'b111} || exp_cnt16 != 0) begin
            n_bad++;
            $display("FAIL clear_priority: got cnt4=%0d cnt16=%0d pulse=%b locked=%b want 0/0/1/1",
                     err_count4, err_count, err_pulse, locked);
        end
        drive(1'b1, gen_bit(), 1'b0);
    endtask

    task automatic test_gapped_reset();
        int valid = 0;
        int errs  = 0;
        bit e;
        apply_reset();
        gen = 8'(($urandom_range(1, 255)));
        for (int cyc = 0; cyc < 2000 && valid < 24; cyc++) begin
            e = ($urandom_range(0, 99) < 30);
            drive(e, e ? gen_bit() : 1'($urandom), 1'b0);
            if (e) valid++;
            n_cmp++;
            if ({locked, err_pulse, data_out} !== {(valid >= 24), 1'b0, exp_hist()} || exp_locked != (valid >= 24)) begin
                n_bad++;
                $display("FAIL gapped_lock cycle %0d valid %0d: got locked=%b pulse=%b hist=%h want %b/0/%h",
                         cyc, valid, locked, err_pulse, data_out, (valid >= 24), exp_hist());
            end
        end
        n_cmp++;
        if (valid != 24) begin
            n_bad++;
            $display("FAIL gapped_lock_budget: got %0d valid bits want 24", valid);
        end
        valid = 0;
        for (int cyc = 0; cyc < 2000 && valid < 20; cyc++) begin
            e = ($urandom_range(0, 99) < 30);
            drive(e, e ? (gen_bit() ^ (valid < 8)) : 1'($urandom), 1'b0);
            if (e) valid++;
            if (err_pulse === 1'b1) errs++;
            n_cmp++;
            if ({locked, err_pulse, err_count, data_out} !== {exp_locked, exp_pulse, 16'(exp_cnt16), exp_hist()}) begin
                n_bad++;
                $display("FAIL gapped_loss cycle %0d: got %b/%b/%0d/%h want %b/%b/%0d/%h", cyc,
                         locked, err_pulse, err_count, data_out, exp_locked, exp_pulse, exp_cnt16, exp_hist());
            end
        end
        n_cmp++;
        if (errs != 8 || err_count !== 16'd8 || locked !== 1'b0 || m_mode != M_VERIFY) begin
            n_bad++;
            $display("FAIL gapped_pre_reset: got pulses=%0d cnt=%0d locked=%b want 8/8/0", errs, err_count, locked);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({locked, err_pulse, err_count, err_count4, data_out} !== 30'd0) begin
            n_bad++;
            $display("FAIL async_reset: got locked=%b pulse=%b cnt=%0d cnt4=%0d hist=%h want all zero",
                     locked, err_pulse, err_count, err_count4, data_out);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean_lock();
        test_single_error();
        test_loss_of_lock();
        test_invalid_stream();
        test_saturation();
        test_gapped_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prbs_checker_8.md
Name: prbs_checker_8

Overview:
- Receive-side companion to the team's 8-bit Fibonacci LFSR generator.
- Consumes the generator's serial output one bit per enabled cycle and self-synchronises to the PRBS.
- Once locked, flags and counts bit errors against a free-running local predictor.
- Sits at the far end of a serial link or loopback path in the lab test harness, driving LEDs and the 7-seg error display.

Parameters:
- LOCK_COUNT, 16: consecutive correct predictions required in VERIFY before asserting locked (range 1..255).
- LOSS_COUNT, 8: consecutive mismatches in LOCKED that force resynchronisation (range 1..255).
- CNT_W, 16: width of the error counter.

Ports:
- clk, input, 1: system clock, all state on rising edge.
- rst, input, 1: asynchronous active-high reset.
- en, input, 1: bit_in valid this cycle; no state changes when low.
- bit_in, input, 1: received serial PRBS bit (generator data_out[0] after each shift).
- clr_cnt, input, 1: synchronous clear of err_count.
- locked, output, 1: checker is in LOCKED state.
- err_pulse, output, 1: one-cycle pulse, registered, for each mismatched bit while LOCKED.
- err_count, output, CNT_W: saturating count of errors while LOCKED.
- data_out, output, 8: current predictor history register.

Behaviour:
- Sequence model: b[n] = b[n-8] ^ b[n-4] ^ b[n-3] ^ b[n-2]. This is the x^8+x^4+x^3+x^2+1 generator with taps 7,3,2,1, new bit at LSB.
- History register hist[7:0]: hist[0] is the newest bit.
- Prediction is combinational: pred = hist[7]^hist[3]^hist[2]^hist[1]. mismatch = en & (bit_in != pred).
- Reset (async, rst=1) sets:
  - state=SEARCH, hist=8'h00, fill counter=0, run counter=0;
  - locked=0, err_pulse=0, err_count=0.
  - Reset mid-operation abandons lock immediately; no pending pulse survives.
- All transitions below occur only on cycles with en=1. With en=0, all registers hold, except err_pulse, which returns to 0.
- SEARCH:
  - Shift bit_in into hist and increment the fill counter.
  - When the 8th bit is shifted in:
    - resulting hist != 0: go to VERIFY, run counter=0.
    - resulting hist == 0 (invalid LFSR state): stay in SEARCH, fill counter=0.
- VERIFY:
  - Shift bit_in into hist (self-synchronising).
  - Correct bit: run counter+1. On reaching LOCK_COUNT, go to LOCKED, run counter=0.
  - Mismatch: go to SEARCH, fill counter=0. hist is retained but refilled.
- LOCKED:
  - Shift pred, not bit_in, into hist. Each channel error is counted exactly once, with no error multiplication.
  - Mismatch: err_pulse=1 on the next cycle; err_count+1, saturating at all-ones; run counter+1.
  - Correct bit: run counter=0.
  - Run counter reaching LOSS_COUNT: go to SEARCH, fill counter=0. The LOSS_COUNT-th mismatch is still counted and pulsed.
- locked is a registered decode of state. It rises on the edge that accepts the (8+LOCK_COUNT)-th valid bit after reset on a clean stream, and falls on the edge that accepts the LOSS_COUNT-th consecutive error.
- clr_cnt:
  - Clears err_count to 0 on the next edge and has priority over increment in the same cycle.
  - Does not affect state or err_pulse.
- err_count is frozen outside LOCKED; it is not cleared on loss of lock.

Decomposition:
- Package prbs_pkg:
  - state typedef enum {SEARCH, VERIFY, LOCKED} (2 bits);
  - localparam tap mask 8'b1000_1110;
  - localparam SEQ_LEN=255.
- One natural sub-module, prbs_predictor_8: the hist register plus tap XOR, with a load-select input choosing bit_in or pred. The FSM and counters stay in the top level.

Test Plan:
- Clean lock: generator seeded 8'h01, en=1 continuously. Required: locked=1 after the 24th bit; then 1000 bits with err_pulse=0 and err_count=0.
- Single injected error: invert 1 bit while locked. Required: exactly one err_pulse one cycle later, err_count=1, locked stays 1. Confirms there is no multiplication.
- Loss of lock: force bit_in=0 for 8 bits, with at least 8 predicted 1s in the window, or invert 8 consecutive bits. Required: locked falls on the 8th error, err_count increases by 8, then relock after a further 24 clean bits.
- Invalid stream: bit_in held 0 for 100 bits. Required: locked never asserts and state stays in SEARCH.
- Gapped enable and reset: random en duty of 30%. Required: lock time counted in valid bits only (24). Assert rst mid-VERIFY, then check locked=0 and err_count=0 immediately and asynchronously.
- Saturation and clear: CNT_W=4 build, inject 20 isolated errors. Required: err_count=15. Then clr_cnt together with an error in the same cycle. Required: err_count=0.
